// File: rtl/safe_softmax_exp2_pipe.sv
// safe_softmax_exp2_pipe
// Multi-lane 2^x unit for max-subtracted scores (x <= 0), placed between the
// max-subtract stage and the exp-sum accumulator.
//   S1: clamp x > 0 to 0 and flag it; split x into a right-shift amount and
//       a fraction (segment index + offset inside the segment)
//   S2: chord slope times offset, full-width product
//   S3: base + truncated product, shifted right by the integer part; masking
// All stages advance together on en = ~O_VLD | I_RDY, so bubbles also hold
// under backpressure.
module safe_softmax_exp2_pipe #(
    parameter int D_W    = 16,
    parameter int FRAC_W = 13,
    parameter int SEG    = 4,
    parameter int LANES  = 1
) (
    input  logic                 I_CLK,
    input  logic                 I_RST_N,
    input  logic                 I_VLD,
    output logic                 O_RDY,
    input  logic [LANES*D_W-1:0] I_X,
    input  logic [LANES-1:0]     I_MASK,
    input  logic                 I_LAST,
    output logic                 O_VLD,
    input  logic                 I_RDY,
    output logic [LANES*D_W-1:0] O_Y,
    output logic                 O_LAST,
    output logic [LANES-1:0]     O_ERR
);

    localparam int IDX_W = $clog2(SEG);
    localparam int OFF_W = FRAC_W - IDX_W;
    // Integer part of a clamped x lies in [-2^(SH_W-1), 0], so -n fits SH_W bits.
    localparam int SH_W  = D_W - FRAC_W;
    // 2^(i/SEG) < 2 and the chord slope stays below 2*ln2, so both fit FRAC_W+1 bits.
    localparam int A_W   = FRAC_W + 1;
    localparam int B_W   = FRAC_W + 1;
    localparam int P_W   = B_W + OFF_W;
    localparam int M_W   = FRAC_W + 2;

    typedef logic [SEG-1:0][A_W-1:0] a_rom_t;
    typedef logic [SEG-1:0][B_W-1:0] b_rom_t;

    // Segment base values: round(2^(i/SEG) * 2^FRAC_W).
    function automatic a_rom_t gen_a_rom();
        a_rom_t rom;
        real    scale;
        scale = real'(longint'(1) << FRAC_W);
        for (int i = 0; i < SEG; i++) begin
            rom[i] = A_W'($rtoi(2.0 ** (real'(i) / real'(SEG)) * scale + 0.5));
        end
        return rom;
    endfunction

    // Chord slopes, scaled by SEG so that offset * slope needs one shift by FRAC_W.
    function automatic b_rom_t gen_b_rom();
        b_rom_t rom;
        real    scale;
        real    lo;
        real    hi;
        scale = real'(longint'(1) << FRAC_W);
        for (int i = 0; i < SEG; i++) begin
            lo     = 2.0 ** (real'(i) / real'(SEG));
            hi     = 2.0 ** (real'(i + 1) / real'(SEG));
            rom[i] = B_W'($rtoi((hi - lo) * real'(SEG) * scale + 0.5));
        end
        return rom;
    endfunction

    localparam a_rom_t A_ROM = gen_a_rom();
    localparam b_rom_t B_ROM = gen_b_rom();

    logic                        en;
    logic [LANES-1:0][D_W-1:0]   x_lane;

    logic                        s1_vld_q,  s1_vld_d;
    logic                        s1_last_q, s1_last_d;
    logic [LANES-1:0][SH_W-1:0]  s1_sh_q,   s1_sh_d;
    logic [LANES-1:0][IDX_W-1:0] s1_idx_q,  s1_idx_d;
    logic [LANES-1:0][OFF_W-1:0] s1_off_q,  s1_off_d;
    logic [LANES-1:0]            s1_mask_q, s1_mask_d;
    logic [LANES-1:0]            s1_err_q,  s1_err_d;

    logic                        s2_vld_q,  s2_vld_d;
    logic                        s2_last_q, s2_last_d;
    logic [LANES-1:0][SH_W-1:0]  s2_sh_q,   s2_sh_d;
    logic [LANES-1:0][IDX_W-1:0] s2_idx_q,  s2_idx_d;
    logic [LANES-1:0][P_W-1:0]   s2_p_q,    s2_p_d;
    logic [LANES-1:0]            s2_mask_q, s2_mask_d;
    logic [LANES-1:0]            s2_err_q,  s2_err_d;

    logic                        o_vld_q,   o_vld_d;
    logic                        o_last_q,  o_last_d;
    logic [LANES-1:0][D_W-1:0]   o_y_q,     o_y_d;
    logic [LANES-1:0]            o_err_q,   o_err_d;

    assign x_lane = I_X;
    assign en     = ~o_vld_q | I_RDY;

    assign O_RDY  = en;
    assign O_VLD  = o_vld_q;
    assign O_Y    = o_y_q;
    assign O_LAST = o_last_q;
    assign O_ERR  = o_err_q;

    // S1: clamp positive inputs, split into shift / segment index / offset.
    always_comb begin
        logic             pos;
        logic [D_W-1:0]   xc;
        pos       = 1'b0;
        xc        = '0;
        s1_vld_d  = s1_vld_q;
        s1_last_d = s1_last_q;
        s1_sh_d   = s1_sh_q;
        s1_idx_d  = s1_idx_q;
        s1_off_d  = s1_off_q;
        s1_mask_d = s1_mask_q;
        s1_err_d  = s1_err_q;
        if (en) begin
            s1_vld_d = I_VLD;
            if (I_VLD) begin
                s1_last_d = I_LAST;
                for (int k = 0; k < LANES; k++) begin
                    pos          = ~x_lane[k][D_W-1] & (|x_lane[k][D_W-2:0]);
                    xc           = pos ? '0 : x_lane[k];
                    s1_err_d[k]  = pos;
                    s1_mask_d[k] = I_MASK[k];
                    // sh = -floor(x): two's-complement negate of the integer field
                    s1_sh_d[k]   = ~xc[D_W-1:FRAC_W] + SH_W'(1);
                    s1_idx_d[k]  = xc[FRAC_W-1 -: IDX_W];
                    s1_off_d[k]  = xc[OFF_W-1:0];
                end
            end
        end
    end

    // S2: full-width slope * offset product; truncation happens once in S3.
    always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_last_d = s2_last_q;
        s2_sh_d   = s2_sh_q;
        s2_idx_d  = s2_idx_q;
        s2_p_d    = s2_p_q;
        s2_mask_d = s2_mask_q;
        s2_err_d  = s2_err_q;
        if (en) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_last_d = s1_last_q;
                s2_sh_d   = s1_sh_q;
                s2_idx_d  = s1_idx_q;
                s2_mask_d = s1_mask_q;
                s2_err_d  = s1_err_q;
                for (int k = 0; k < LANES; k++) begin
                    s2_p_d[k] = P_W'(B_ROM[s1_idx_q[k]]) * P_W'(s1_off_q[k]);
                end
            end
        end
    end

    // S3: interpolate, apply the integer shift and the mask into the output register.
    always_comb begin
        logic [M_W-1:0] m;
        m        = '0;
        o_vld_d  = o_vld_q;
        o_last_d = o_last_q;
        o_y_d    = o_y_q;
        o_err_d  = o_err_q;
        if (en) begin
            o_vld_d = s2_vld_q;
            // Data only moves with a real beat, so outputs keep their last value
            // across bubbles.
            if (s2_vld_q) begin
                o_last_d = s2_last_q;
                for (int k = 0; k < LANES; k++) begin
                    m = M_W'(A_ROM[s2_idx_q[k]]) + M_W'(s2_p_q[k] >> FRAC_W);
                    // A logical shift by >= M_W already yields zero.
                    if (s2_mask_q[k]) begin
                        o_y_d[k] = '0;
                    end else begin
                        o_y_d[k] = D_W'(m >> s2_sh_q[k]);
                    end
                    o_err_d[k] = s2_err_q[k] & ~s2_mask_q[k];
                end
            end
        end
    end

    // Pipeline registers; reset empties the pipe and clears the outputs.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_sh_q   <= '0;
            s1_idx_q  <= '0;
            s1_off_q  <= '0;
            s1_mask_q <= '0;
            s1_err_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_sh_q   <= '0;
            s2_idx_q  <= '0;
            s2_p_q    <= '0;
            s2_mask_q <= '0;
            s2_err_q  <= '0;
            o_vld_q   <= 1'b0;
            o_last_q  <= 1'b0;
            o_y_q     <= '0;
            o_err_q   <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_sh_q   <= s1_sh_d;
            s1_idx_q  <= s1_idx_d;
            s1_off_q  <= s1_off_d;
            s1_mask_q <= s1_mask_d;
            s1_err_q  <= s1_err_d;
            s2_vld_q  <= s2_vld_d;
            s2_last_q <= s2_last_d;
            s2_sh_q   <= s2_sh_d;
            s2_idx_q  <= s2_idx_d;
            s2_p_q    <= s2_p_d;
            s2_mask_q <= s2_mask_d;
            s2_err_q  <= s2_err_d;
            o_vld_q   <= o_vld_d;
            o_last_q  <= o_last_d;
            o_y_q     <= o_y_d;
            o_err_q   <= o_err_d;
        end
    end

endmodule

// File: tb/tb_safe_softmax_exp2_pipe.sv
// Bench for safe_softmax_exp2_pipe: a single-lane and a four-lane instance
// (D_W=16, FRAC_W=13, SEG=4) sharing one clock.
module tb_safe_softmax_exp2_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        vld1, rdy1_o, last1, mask1, ovld1, irdy1, olast1, err1;
    logic [15:0] x1, y1;

    logic        vld4, rdy4_o, last4, ovld4, irdy4, olast4;
    logic [63:0] x4, y4;
    logic [3:0]  mask4, err4;

    safe_softmax_exp2_pipe #(.D_W(16), .FRAC_W(13), .SEG(4), .LANES(1)) u1 (
        .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(vld1), .O_RDY(rdy1_o), .I_X(x1),
        .I_MASK(mask1), .I_LAST(last1), .O_VLD(ovld1), .I_RDY(irdy1), .O_Y(y1),
        .O_LAST(olast1), .O_ERR(err1)
    );

    safe_softmax_exp2_pipe #(.D_W(16), .FRAC_W(13), .SEG(4), .LANES(4)) u4 (
        .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(vld4), .O_RDY(rdy4_o), .I_X(x4),
        .I_MASK(mask4), .I_LAST(last4), .O_VLD(ovld4), .I_RDY(irdy4), .O_Y(y4),
        .O_LAST(olast4), .O_ERR(err4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] x;
        logic        mask;
        int          y;
        logic        err;
    } vec_t;

    vec_t vecs [14];
    int   bp_y [8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit hit, got 1 required 0");
        $fatal(1, "time limit");
    end

    initial begin
        int   lat;
        int   sent;
        int   recv;
        int   held;
        int   stalled;
        int   q [$];
        int   xv;
        int   xe;
        int   refv;
        int   diff;
        int   prev;
        int   budget;
        int   stale;
        int   exp4 [4];

        rst_n = 1'b0;
        vld1 = 1'b0; x1 = '0; mask1 = 1'b0; last1 = 1'b0; irdy1 = 1'b1;
        vld4 = 1'b0; x4 = '0; mask4 = '0;   last4 = 1'b0; irdy4 = 1'b1;

        vecs[0]  = '{16'(0),      1'b0, 8192, 1'b0};
        vecs[1]  = '{16'(-8192),  1'b0, 4096, 1'b0};
        vecs[2]  = '{16'(-4096),  1'b0, 5792, 1'b0};
        vecs[3]  = '{16'(-32768), 1'b0, 512,  1'b0};
        vecs[4]  = '{16'(100),    1'b0, 8192, 1'b1};
        vecs[5]  = '{16'(-4096),  1'b1, 0,    1'b0};
        vecs[6]  = '{16'(-1),     1'b0, 8191, 1'b0};
        vecs[7]  = '{16'(-2048),  1'b0, 6888, 1'b0};
        vecs[8]  = '{16'(-6144),  1'b0, 4871, 1'b0};
        vecs[9]  = '{16'(-24576), 1'b0, 1024, 1'b0};
        vecs[10] = '{16'(-1024),  1'b0, 7540, 1'b0};
        vecs[11] = '{16'(32767),  1'b0, 8192, 1'b1};
        vecs[12] = '{16'(-32767), 1'b0, 512,  1'b0};
        vecs[13] = '{16'(100),    1'b1, 0,    1'b0};
        bp_y = '{8192, 7540, 6888, 6340, 5792, 5331, 4871, 4483};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld",  ovld1 == 1'b0, ovld1, 0);
        check("rst_y",    y1 == 16'd0, y1, 0);
        check("rst_last", olast1 == 1'b0, olast1, 0);
        check("rst_err",  err1 == 1'b0, err1, 0);
        check("rst_vld4", ovld4 == 1'b0, ovld4, 0);
        check("rst_y4",   y4 == 64'd0, y4, 0);
        rst_n = 1'b1;
        step();

        // table of single beats
        for (int i = 0; i < 14; i++) begin
            x1 = vecs[i].x; mask1 = vecs[i].mask; vld1 = 1'b1;
            step();
            vld1 = 1'b0; mask1 = 1'b0;
            lat = 1;
            while (!ovld1 && lat < 10) begin
                step();
                lat++;
            end
            check($sformatf("vec%0d_lat", i), lat == 3, lat, 3);
            check($sformatf("vec%0d_y", i), int'(y1) == vecs[i].y, y1, vecs[i].y);
            check($sformatf("vec%0d_err", i), err1 == vecs[i].err, err1, vecs[i].err);
            step();
        end

        // backpressure: 8 beats, downstream stalls in cycles 4..7
        sent = 0; recv = 0; held = 0; stalled = 0;
        for (int c = 1; c <= 30; c++) begin
            irdy1 = !(c >= 4 && c <= 7);
            vld1  = (sent < 8);
            x1    = 16'(-1024 * sent);
            last1 = (sent == 7);
            #1;
            if (ovld1) begin
                if (irdy1) begin
                    if (recv < 8) begin
                        check($sformatf("bp_y%0d", recv), int'(y1) == bp_y[recv], y1, bp_y[recv]);
                        check($sformatf("bp_last%0d", recv), olast1 == (recv == 7), olast1, recv == 7);
                        recv++;
                    end else begin
                        check("bp_dup", 1'b0, recv + 1, 8);
                    end
                    stalled = 0;
                end else begin
                    check($sformatf("bp_ordy_c%0d", c), rdy1_o == 1'b0, rdy1_o, 0);
                    if (stalled != 0) begin
                        check($sformatf("bp_hold_c%0d", c), int'(y1) == held, y1, held);
                    end
                    held = int'(y1);
                    stalled = 1;
                end
            end
            if (vld1 && rdy1_o) sent++;
            step();
        end
        check("bp_count", recv == 8 && sent == 8, recv, 8);
        vld1 = 1'b0; last1 = 1'b0; irdy1 = 1'b1;
        step();

        // four independent lanes
        check("l4_rdy", rdy4_o == 1'b1, rdy4_o, 1);
        x4    = {16'(1), 16'(-16384), 16'(-8192), 16'(0)};
        mask4 = 4'b0100;
        vld4  = 1'b1;
        step();
        vld4 = 1'b0; mask4 = '0;
        lat = 1;
        while (!ovld4 && lat < 10) begin
            step();
            lat++;
        end
        check("l4_lat", lat == 3, lat, 3);
        exp4 = '{8192, 4096, 0, 8192};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("l4_y%0d", k), int'(y4[k*16 +: 16]) == exp4[k], y4[k*16 +: 16], exp4[k]);
        end
        check("l4_err", err4 == 4'b1000, err4, 8);
        check("l4_last", olast4 == 1'b0, olast4, 0);
        step();

        // full-range sweep against a real-valued reference
        xv = 0; prev = 1 << 30; budget = 0;
        while ((xv >= -32768 || q.size() > 0) && budget < 40000) begin
            if (ovld1) begin
                if (q.size() == 0) begin
                    check("sweep_extra", 1'b0, y1, 0);
                end else begin
                    xe   = q.pop_front();
                    refv = $rtoi(2.0 ** (real'(xe) / 8192.0) * 8192.0 + 0.5);
                    diff = int'(y1) - refv;
                    check($sformatf("sweep_acc_x%0d", xe), diff <= 64 && diff >= -64, y1, refv);
                    check($sformatf("sweep_mono_x%0d", xe), int'(y1) <= prev, y1, prev);
                    check($sformatf("sweep_err_x%0d", xe), err1 == 1'b0, err1, 0);
                    prev = int'(y1);
                end
            end
            if (xv >= -32768) begin
                vld1 = 1'b1;
                x1   = 16'(xv);
                q.push_back(xv);
                xv--;
            end else begin
                vld1 = 1'b0;
            end
            step();
            budget++;
        end
        vld1 = 1'b0;
        check("sweep_done", q.size() == 0 && xv < -32768, q.size(), 0);
        repeat (3) step();

        // asynchronous reset with two beats in flight
        irdy1 = 1'b0;
        vld1 = 1'b1; x1 = 16'(0);
        step();
        x1 = 16'(-8192);
        step();
        vld1 = 1'b0;
        step();
        check("ar_pre_vld", ovld1 == 1'b1, ovld1, 1);
        check("ar_pre_y", y1 == 16'd8192, y1, 8192);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_vld", ovld1 == 1'b0, ovld1, 0);
        check("ar_y", y1 == 16'd0, y1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        irdy1 = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (ovld1) stale++;
        end
        check("ar_no_stale", stale == 0, stale, 0);
        check("ar_y_after", y1 == 16'd0, y1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
